// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers, types and messages shared by the fifo wrappers and the upsizer
package fifo_pkg;
  function automatic int clog2_min1(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  localparam int DEF_RATIO = 4;
  typedef logic [$clog2(DEF_RATIO+1)-1:0] def_count_t;
  localparam string MSG_DEQ_EMPTY = "Dequeuing from empty upsizer";
endpackage

// File: rtl/fifo_upsizer_lane_mux.sv
// fifo_upsizer_lane_mux: assembles the wide word from accumulated lanes plus the closing beat
module fifo_upsizer_lane_mux
  import fifo_pkg::*;
#(
  parameter int in_width = 8,
  parameter int ratio = 4,
  localparam int cw = clog2_min1(ratio)
) (
  input  logic [in_width-1:0]       acc [ratio-1],
  input  logic [in_width-1:0]       in_d,
  input  logic [cw-1:0]             cnt,
  output logic [in_width*ratio-1:0] word
);
  for (genvar i = 0; i < ratio; i++) begin : g_lane
    if (i < ratio - 1) begin : g_acc
      assign word[i*in_width +: in_width] = (cw'(i) < cnt) ? acc[i] : (cw'(i) == cnt) ? in_d : '0;
    end else begin : g_top
      assign word[i*in_width +: in_width] = (cw'(i) == cnt) ? in_d : '0;
    end
  end
endmodule

// File: rtl/fifo_upsizer.sv
// fifo_upsizer: packs narrow FIFO2 beats into wide words behind a FIFO-style dequeue port
module fifo_upsizer
  import fifo_pkg::*;
#(
  parameter int   in_width = 8,
  parameter int   ratio = 4,
  parameter logic guarded = 1'b1,
  localparam int  cw = clog2_min1(ratio),
  localparam int  ow = $clog2(ratio + 1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      CLR,
  input  logic [in_width-1:0]       IN_D,
  input  logic                      IN_LAST,
  input  logic                      IN_EMPTY_N,
  output logic                      IN_DEQ,
  output logic [in_width*ratio-1:0] OUT_D,
  output logic [ow-1:0]             OUT_COUNT,
  output logic                      OUT_LAST,
  output logic                      OUT_EMPTY_N,
  input  logic                      OUT_DEQ
);
  if (ratio < 2) begin : g_bad_ratio
    $error("fifo_upsizer: ratio must be >= 2");
  end
  logic [in_width-1:0]       acc [ratio-1];
  logic [cw-1:0]             cnt;
  logic [in_width*ratio-1:0] out_d, word;
  logic [ow-1:0]             out_count;
  logic                      out_last, out_valid, completing;
  assign completing = (cnt == cw'(ratio - 1)) || IN_LAST;
  // OUT_DEQ feeds IN_DEQ combinationally so a full output register reloads without a bubble
  assign IN_DEQ = IN_EMPTY_N && !CLR && !RST && (!completing || !out_valid || OUT_DEQ);
  fifo_upsizer_lane_mux #(.in_width(in_width), .ratio(ratio)) u_mux (
    .acc (acc),
    .in_d(IN_D),
    .cnt (cnt),
    .word(word)
  );
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      acc <= '{default: '0};
      out_d <= '0;
      out_count <= '0;
      out_last <= 1'b0;
      out_valid <= 1'b0;
    end else if (CLR) begin
      cnt <= '0;
      out_valid <= 1'b0;
    end else if (IN_DEQ && completing) begin
      out_d <= word;
      out_count <= ow'(cnt) + ow'(1);
      out_last <= IN_LAST;
      out_valid <= 1'b1;
      cnt <= '0;
    end else begin
      if (IN_DEQ) begin
        acc[cnt] <= IN_D;
        cnt <= cnt + cw'(1);
      end
      if (OUT_DEQ) out_valid <= 1'b0;
    end
  end
  always @(posedge CLK) if (guarded && OUT_DEQ && !out_valid && !RST) $warning("%s", MSG_DEQ_EMPTY);
  assign OUT_D = out_d;
  assign OUT_COUNT = out_count;
  assign OUT_LAST = out_last;
  assign OUT_EMPTY_N = out_valid;
endmodule
